// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N-channel dual-edge detector.
// Each channel has a level synchroniser, a 5-state Moore FSM that turns a
// synchronised level change into a one-cycle rise/fall pulse, a mode-gated
// tick, and a sticky pending flag feeding a registered interrupt line.
// Optional glitch filter between synchroniser and FSM: define MEDGE_FILTER_EN.
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   level,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  input  logic [N_CH-1:0]   irq_mask,
  output logic              ready,
  output logic [N_CH-1:0]   rise,
  output logic [N_CH-1:0]   fall,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES) + 1;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_ZERO      = 3'd1;
  localparam logic [2:0] ST_EDGE_UP   = 3'd2;
  localparam logic [2:0] ST_ONE       = 3'd3;
  localparam logic [2:0] ST_EDGE_DOWN = 3'd4;

  if (N_CH < 1) begin : g_bad_n_ch
    $error("N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be >= 1");
  end

  logic [CNT_W-1:0] init_cnt;
  logic             init_load;

  // The last init count is the cycle where every FSM takes its starting level.
  assign init_load = !ready && (init_cnt == CNT_W'(SYNC_STAGES - 1));

  // Init counter: let the synchronisers fill before any FSM leaves INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (!ready) begin
      init_cnt <= init_cnt + CNT_W'(1);
      if (init_load) ready <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_level;
    logic                   s_next;
    logic                   fsm_in;
    logic [2:0]             state;
    logic [2:0]             state_next;

    assign s_level = sync_q[SYNC_STAGES-1];
    // Value entering the last synchroniser flop; loading from it makes the FSM
    // agree with s_level right after init, so the initial level never shows as an edge.
    assign s_next  = sync_q[SYNC_STAGES-2];

    // Synchroniser shift chain for the asynchronous board level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], level[i]};
    end

`ifdef MEDGE_FILTER_EN
    localparam int FCNT_W = $clog2(FILTER_LEN) + 1;
    logic              f_level;
    logic [FCNT_W-1:0] f_cnt;

    // Glitch filter: follow s_level only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        f_level <= 1'b0;
        f_cnt   <= '0;
      end else if (init_load) begin
        f_level <= s_next;
        f_cnt   <= '0;
      end else if (s_level != f_level) begin
        if (f_cnt == FCNT_W'(FILTER_LEN - 1)) begin
          f_level <= s_level;
          f_cnt   <= '0;
        end else begin
          f_cnt <= f_cnt + FCNT_W'(1);
        end
      end else begin
        f_cnt <= '0;
      end
    end

    assign fsm_in = f_level;
`else
    assign fsm_in = s_level;
`endif

    // Next-state logic; EDGE states always pass through ONE/ZERO so events are >= 2 cycles apart.
    always_comb begin
      state_next = state;
      case (state)
        ST_INIT:      if (init_load) state_next = s_next ? ST_ONE : ST_ZERO;
        ST_ZERO:      if (fsm_in)    state_next = ST_EDGE_UP;
        ST_EDGE_UP:                  state_next = ST_ONE;
        ST_ONE:       if (!fsm_in)   state_next = ST_EDGE_DOWN;
        ST_EDGE_DOWN:                state_next = ST_ZERO;
        default:                     state_next = ST_INIT;
      endcase
    end

    // Channel state register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_INIT;
      else       state <= state_next;
    end

    assign rise[i] = (state == ST_EDGE_UP);
    assign fall[i] = (state == ST_EDGE_DOWN);
    assign tick[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
  end

  // Sticky pending flags: a new tick beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr) | tick;
  end

  // Registered interrupt, one cycle behind pending and irq_mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pending & irq_mask);
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector (default build, no glitch filter).
// A driver applies inputs shortly after each rising edge, pushes the outputs a
// behavioural model expects for that cycle, then advances the model. A monitor
// pops one expectation per falling edge and compares it with the DUT outputs.
module tb_multi_edge_detector;
  localparam int NC = 4;
  localparam int SS = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   level;
  logic [2*NC-1:0] mode;
  logic [NC-1:0]   clr;
  logic [NC-1:0]   irq_mask;
  logic            ready;
  logic [NC-1:0]   rise, fall, tick, pending;
  logic            irq;

  always #5 clk = ~clk;

  multi_edge_detector #(.N_CH(NC), .SYNC_STAGES(SS), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .irq_mask(irq_mask), .ready(ready), .rise(rise), .fall(fall),
    .tick(tick), .pending(pending), .irq(irq)
  );

  typedef struct packed {
    logic          rdy;
    logic [NC-1:0] rs;
    logic [NC-1:0] fl;
    logic [NC-1:0] tk;
    logic [NC-1:0] pd;
    logic          iq;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Reference model: input history, edge counter since reset release,
  // last reported level per channel, event shown this cycle (0 none, 1 rise, 2 fall).
  logic [NC-1:0] hist[$];
  int            n_edges;
  bit            m_ready;
  logic [NC-1:0] m_rep;
  int            m_ev[NC];
  logic [NC-1:0] m_pend;
  logic          m_irq;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SS; k++) hist.push_back('0);
    n_edges = 0;
    m_ready = 1'b0;
    m_rep   = '0;
    m_pend  = '0;
    m_irq   = 1'b0;
    for (int k = 0; k < NC; k++) m_ev[k] = 0;
  endtask

  function automatic logic [NC-1:0] model_tick(input logic [2*NC-1:0] md);
    logic [NC-1:0] t;
    for (int k = 0; k < NC; k++)
      t[k] = ((m_ev[k] == 1) && md[2*k]) || ((m_ev[k] == 2) && md[2*k+1]);
    return t;
  endfunction

  task automatic push_expect();
    obs_t e;
    e.rdy = m_ready;
    for (int k = 0; k < NC; k++) begin
      e.rs[k] = (m_ev[k] == 1);
      e.fl[k] = (m_ev[k] == 2);
    end
    e.tk = model_tick(mode);
    e.pd = m_pend;
    e.iq = m_irq;
    sb.push_back(e);
  endtask

  // Advance the model across one rising edge with the inputs now applied.
  task automatic model_step();
    logic [NC-1:0] tk;
    logic [NC-1:0] s_old;
    logic [NC-1:0] s_new;
    logic          nirq;
    tk     = model_tick(mode);
    nirq   = |(m_pend & irq_mask);
    m_pend = (m_pend & ~clr) | tk;
    m_irq  = nirq;
    s_old  = hist[0];
    hist.push_back(level);
    void'(hist.pop_front());
    s_new  = hist[0];
    if (!m_ready) begin
      n_edges++;
      if (n_edges == SS) begin
        m_ready = 1'b1;
        m_rep   = s_new;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (m_ev[k] != 0) m_ev[k] = 0;
        else if (s_old[k] != m_rep[k]) begin
          m_ev[k]  = s_old[k] ? 1 : 2;
          m_rep[k] = s_old[k];
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [NC-1:0] lv, input logic [2*NC-1:0] md,
                     input logic [NC-1:0] cl, input logic [NC-1:0] mk);
    @(posedge clk);
    #2;
    reset = r; level = lv; mode = md; clr = cl; irq_mask = mk;
    if (r) model_reset();
    push_expect();
    if (!r) model_step();
  endtask

  obs_t mon_e, mon_a;

  // Monitor: one comparison per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow t=%0t: no expectation queued, required one", $time);
      end else begin
        mon_e = sb.pop_front();
        mon_a = {ready, rise, fall, tick, pending, irq};
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL outputs t=%0t actual rdy=%b rise=%b fall=%b tick=%b pend=%b irq=%b required rdy=%b rise=%b fall=%b tick=%b pend=%b irq=%b",
                   $time, mon_a.rdy, mon_a.rs, mon_a.fl, mon_a.tk, mon_a.pd, mon_a.iq,
                   mon_e.rdy, mon_e.rs, mon_e.fl, mon_e.tk, mon_e.pd, mon_e.iq);
        end
      end
    end
  end

  initial begin
    logic [NC-1:0]   lv;
    logic [2*NC-1:0] md;
    logic [NC-1:0]   mk;
    logic [NC-1:0]   cl;
    reset = 1'b1; level = '0; mode = 8'hFF; clr = '0; irq_mask = '1;
    model_reset();

    // All levels low through reset: ready after SYNC_STAGES edges, nothing reported.
    repeat (3)  cyc(1'b1, 4'h0, 8'hFF, 4'h0, 4'hF);
    repeat (12) cyc(1'b0, 4'h0, 8'hFF, 4'h0, 4'hF);

    // ch0 high through reset: initialises to ONE with no rise.
    repeat (3)  cyc(1'b1, 4'h1, 8'hFF, 4'h0, 4'hF);
    repeat (10) cyc(1'b0, 4'h1, 8'hFF, 4'h0, 4'hF);

    // Rising-only mode on ch0, 10-cycle high pulse.
    repeat (2)  cyc(1'b1, 4'h0, 8'h01, 4'h0, 4'h1);
    repeat (6)  cyc(1'b0, 4'h0, 8'h01, 4'h0, 4'h1);
    repeat (10) cyc(1'b0, 4'h1, 8'h01, 4'h0, 4'h1);
    repeat (8)  cyc(1'b0, 4'h0, 8'h01, 4'h0, 4'h1);
    // Clear alone, then a clear landing on the same edge as a new tick.
    cyc(1'b0, 4'h0, 8'h01, 4'h1, 4'h1);
    repeat (3)  cyc(1'b0, 4'h0, 8'h01, 4'h0, 4'h1);
    cyc(1'b0, 4'h1, 8'h01, 4'h0, 4'h1);
    repeat (2)  cyc(1'b0, 4'h1, 8'h01, 4'h0, 4'h1);
    cyc(1'b0, 4'h1, 8'h01, 4'h1, 4'h1);
    repeat (4)  cyc(1'b0, 4'h1, 8'h01, 4'h0, 4'h1);

    // One-cycle pulse on ch2 with both edges enabled.
    cyc(1'b0, 4'h5, 8'hFF, 4'h0, 4'hF);
    repeat (6) cyc(1'b0, 4'h1, 8'hFF, 4'h0, 4'hF);

    // Simultaneous edges on every channel, then reset with events in flight.
    repeat (3) cyc(1'b0, 4'hF, 8'hFF, 4'h0, 4'hF);
    cyc(1'b1, 4'hF, 8'hFF, 4'h0, 4'hF);
    repeat (6) cyc(1'b0, 4'hF, 8'hFF, 4'h0, 4'hF);

    // Randomised traffic with occasional clears, mode/mask changes and resets.
    lv = 4'hF; md = 8'hFF; mk = 4'hF;
    for (int n = 0; n < 2500; n++) begin
      for (int k = 0; k < NC; k++)
        if ($urandom_range(0, 4) == 0) lv[k] = ~lv[k];
      if ($urandom_range(0, 15) == 0) md = 8'($urandom);
      if ($urandom_range(0, 31) == 0) mk = 4'($urandom);
      cl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 249) == 0) begin
        repeat ($urandom_range(1, 2)) cyc(1'b1, lv, md, 4'h0, mk);
      end else begin
        cyc(1'b0, lv, md, cl, mk);
      end
    end

    @(negedge clk);
    #1;
    done = 1'b1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
